vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_pixel_en.sv | 33 +++
 rtl/vga_sync_gen.sv | 80 ++++++++
 tb/tb_vga_sync_gen.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing: 640x480@60 defaults, totals and the counter type used by
// the sync generator and every downstream consumer of row/column.
package vga_pkg;

   localparam int CNT_W        = 10;

   localparam int DEF_CLK_DIV  = 2;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic video_on;
   } sync_t;

   // True when v lies in [lo, lo+len-1].
   function automatic logic in_span(input cnt_t v, input int lo, input int len);
      return (int'(v) >= lo) && (int'(v) < lo + len);
   endfunction

endpackage

// File: rtl/vga_pixel_en.sv
// Pixel-rate enable: divides clk by CLK_DIV; en is high in the clk where the
// divider sits at its last count.
module vga_pixel_en #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   output logic en
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] div_n;

   always_comb begin
      div_n = (div == LAST) ? '0 : div + 1'b1;
   end

   // en is registered from div_n so it lines up with div, and stays low in the
   // clk right after reset even when CLK_DIV is 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         div <= '0;
         en  <= 1'b0;
      end else begin
         div <= div_n;
         en  <= (div_n == LAST);
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel/line counters with hsync, vsync and video_on decoded
// from the next counter values so all outputs change in the same clk.
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic       clk,
   input  logic       reset,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] column,
   output logic [9:0] row,
   output logic       pixel_tick,
   output logic       frame_tick
);

   localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int VS_START = V_ACTIVE + V_FP;

   localparam cnt_t H_LAST   = cnt_t'(HT - 1);
   localparam cnt_t V_LAST   = cnt_t'(VT - 1);
   localparam cnt_t V_BLANK  = cnt_t'(V_ACTIVE);
   localparam cnt_t V_LASTAC = cnt_t'(V_ACTIVE - 1);

   cnt_t  col_n;
   cnt_t  row_n;
   sync_t sync_n;
   logic  h_wrap;

   vga_pixel_en #(.CLK_DIV(CLK_DIV)) u_pixel_en (
      .clk   (clk),
      .reset (reset),
      .en    (pixel_tick)
   );

   always_comb begin
      col_n  = column;
      row_n  = row;
      h_wrap = pixel_tick && (column == H_LAST);
      if (pixel_tick)
         col_n = h_wrap ? '0 : column + 1'b1;
      if (h_wrap)
         row_n = (row == V_LAST) ? '0 : row + 1'b1;
      sync_n.hsync    = !in_span(col_n, HS_START, H_SYNC);
      sync_n.vsync    = !in_span(row_n, VS_START, V_SYNC);
      sync_n.video_on = (int'(col_n) < H_ACTIVE) && (int'(row_n) < V_ACTIVE);
   end

   // Reset values equal the decode of (0,0), so there is no glitch on release.
   always_ff @(posedge clk) begin
      if (reset) begin
         column     <= '0;
         row        <= '0;
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         video_on   <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         column     <= col_n;
         row        <= row_n;
         hsync      <= sync_n.hsync;
         vsync      <= sync_n.vsync;
         video_on   <= sync_n.video_on;
         frame_tick <= (row_n == V_BLANK) && (row == V_LASTAC);
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default timing for line-level checks, a reduced
// raster (CLK_DIV 2 and 1) for frame-level and reset checks.
module tb_vga_sync_gen;

   localparam int SHA = 20, SHF = 4, SHS = 6, SHB = 5;
   localparam int SVA = 12, SVF = 3, SVS = 2, SVB = 4;
   localparam int SHT = SHA + SHF + SHS + SHB;
   localparam int SVT = SVA + SVF + SVS + SVB;

   logic clk = 1'b0;
   logic rst_def = 1'b1, rst_sm = 1'b1, rst_d1 = 1'b1;

   logic d_hs, d_vs, d_vo, d_pt, d_ft;
   logic s_hs, s_vs, s_vo, s_pt, s_ft;
   logic o_hs, o_vs, o_vo, o_pt, o_ft;
   logic [9:0] d_col, d_row, s_col, s_row, o_col, o_row;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vga_sync_gen u_def (
      .clk(clk), .reset(rst_def), .hsync(d_hs), .vsync(d_vs), .video_on(d_vo),
      .column(d_col), .row(d_row), .pixel_tick(d_pt), .frame_tick(d_ft)
   );

   vga_sync_gen #(
      .CLK_DIV(2), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
   ) u_sm (
      .clk(clk), .reset(rst_sm), .hsync(s_hs), .vsync(s_vs), .video_on(s_vo),
      .column(s_col), .row(s_row), .pixel_tick(s_pt), .frame_tick(s_ft)
   );

   vga_sync_gen #(
      .CLK_DIV(1), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
   ) u_d1 (
      .clk(clk), .reset(rst_d1), .hsync(o_hs), .vsync(o_vs), .video_on(o_vo),
      .column(o_col), .row(o_row), .pixel_tick(o_pt), .frame_tick(o_ft)
   );

   // Pixel advances completed before clk n (n = 0 is the clk after reset falls).
   function automatic int ticks_before(input int n, input int d);
      if (n <= 0) return 0;
      return (d == 1) ? n - 1 : n / d;
   endfunction

   // Expected {col,row,hs,vs,vo,pt,ft} for the reduced raster at clk n.
   function automatic logic [24:0] model(input int n, input int d);
      int p, col, row;
      logic hs, vs, vo, pt, ft;
      p   = ticks_before(n, d);
      col = p % SHT;
      row = (p / SHT) % SVT;
      hs  = !(col >= SHA + SHF && col < SHA + SHF + SHS);
      vs  = !(row >= SVA + SVF && row < SVA + SVF + SVS);
      vo  = (col < SHA) && (row < SVA);
      pt  = (d == 1) ? (n >= 1) : ((n % d) == d - 1);
      ft  = (n > 0) && (p != ticks_before(n - 1, d)) && (col == 0) && (row == SVA);
      return {col[9:0], row[9:0], hs, vs, vo, pt, ft};
   endfunction

   task automatic pulse_reset(input int which, input int cycles);
      @(negedge clk);
      case (which)
         0: rst_def = 1'b1;
         1: rst_sm  = 1'b1;
         default: rst_d1 = 1'b1;
      endcase
      repeat (cycles) @(negedge clk);
      case (which)
         0: rst_def = 1'b0;
         1: rst_sm  = 1'b0;
         default: rst_d1 = 1'b0;
      endcase
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({d_col, d_row, d_hs, d_vs, d_vo, d_pt, d_ft} !== {10'd0, 10'd0, 5'b11100}) begin
         errors++;
         $display("FAIL reset_hold_def: got col=%0d row=%0d hs/vs/vo/pt/ft=%b%b%b%b%b, want 0 0 11100",
                  d_col, d_row, d_hs, d_vs, d_vo, d_pt, d_ft);
      end
      checks++;
      if ({o_pt, o_ft, o_vo} !== 3'b001) begin
         errors++;
         $display("FAIL reset_hold_div1: got pt/ft/vo=%b%b%b, want 001", o_pt, o_ft, o_vo);
      end
      pulse_reset(2, 2);
      checks++;
      if ({o_col, o_row, o_hs, o_vs, o_vo, o_pt, o_ft} !== {10'd0, 10'd0, 5'b11100}) begin
         errors++;
         $display("FAIL reset_release_div1: got col=%0d row=%0d flags=%b%b%b%b%b, want 0 0 11100",
                  o_col, o_row, o_hs, o_vs, o_vo, o_pt, o_ft);
      end
   endtask

   task automatic test_pixel_tick();
      logic [9:0] exp_col [6] = '{10'd0, 10'd0, 10'd1, 10'd1, 10'd2, 10'd2};
      logic       exp_pt  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      pulse_reset(0, 3);
      for (int n = 0; n < 6; n++) begin
         if (n > 0) @(negedge clk);
         checks++;
         if (d_col !== exp_col[n] || d_pt !== exp_pt[n]) begin
            errors++;
            $display("FAIL pixel_tick_seq[%0d]: got col=%0d pt=%b, want col=%0d pt=%b",
                     n, d_col, d_pt, exp_col[n], exp_pt[n]);
         end
      end
   endtask

   task automatic test_line();
      int hs_cnt = 0, hs_first = -1, wraps = 0;
      logic [9:0] pcol = '0, prow = '0;
      pulse_reset(0, 2);
      for (int n = 0; n <= 1601; n++) begin
         int p, ec, er;
         if (n > 0) @(negedge clk);
         p = n / 2; ec = p % 800; er = p / 800;
         checks++;
         if (int'(d_col) != ec || int'(d_row) != er ||
             d_hs !== !(ec >= 656 && ec <= 751) || d_vo !== (ec < 640 && er < 480)) begin
            errors++;
            $display("FAIL line_cycle[%0d]: got col=%0d row=%0d hs=%b vo=%b, want col=%0d row=%0d",
                     n, d_col, d_row, d_hs, d_vo, ec, er);
         end
         if (d_pt && n < 1600 && !d_hs) begin
            if (hs_first < 0) hs_first = int'(d_col);
            hs_cnt++;
         end
         if (n > 0 && pcol == 10'd799 && d_col == 10'd0) begin
            wraps++;
            checks++;
            if (d_row !== prow + 10'd1) begin
               errors++;
               $display("FAIL line_row_inc: got row=%0d, want %0d", d_row, prow + 10'd1);
            end
         end
         pcol = d_col; prow = d_row;
      end
      checks++;
      if (hs_cnt != 96 || hs_first != 656) begin
         errors++;
         $display("FAIL hsync_width: got %0d ticks from col %0d, want 96 from 656", hs_cnt, hs_first);
      end
      checks++;
      if (wraps != 1) begin
         errors++;
         $display("FAIL line_wrap: got %0d 799->0 wraps, want 1", wraps);
      end
   endtask

   task automatic test_frames();
      int ft_at [$];
      int vs_ticks = 0, vo_ticks = 0, vs_lo = -1, vs_hi = -1;
      int frame = 2 * SHT * SVT;
      logic [9:0] prow = '0;
      logic seen_640 = 1'b0, seen_480 = 1'b0;
      pulse_reset(1, 2);
      for (int n = 0; n <= 2 * frame + 4; n++) begin
         logic [24:0] e;
         if (n > 0) @(negedge clk);
         e = model(n, 2);
         checks++;
         if ({s_col, s_row, s_hs, s_vs, s_vo, s_pt, s_ft} !== e) begin
            errors++;
            $display("FAIL frame_cycle[%0d]: got col=%0d row=%0d flags=%b%b%b%b%b, want col=%0d row=%0d flags=%b",
                     n, s_col, s_row, s_hs, s_vs, s_vo, s_pt, s_ft, e[24:15], e[14:5], e[4:0]);
         end
         if (s_ft) begin
            ft_at.push_back(n);
            checks++;
            if (s_row !== 10'(SVA) || prow !== 10'(SVA - 1)) begin
               errors++;
               $display("FAIL frame_tick_row: got row %0d->%0d, want %0d->%0d", prow, s_row, SVA - 1, SVA);
            end
         end
         if (s_pt && n < frame) begin
            if (!s_vs) begin
               vs_ticks++;
               if (vs_lo < 0) vs_lo = int'(s_row);
               vs_hi = int'(s_row);
            end
            if (s_vo) vo_ticks++;
            if (s_col == 10'(SHA) && s_row == 10'd0 && !s_vo) seen_640 = 1'b1;
            if (s_col == 10'd0 && s_row == 10'(SVA) && !s_vo) seen_480 = 1'b1;
         end
         prow = s_row;
      end
      checks++;
      if (vs_ticks != SVS * SHT || vs_lo != SVA + SVF || vs_hi != SVA + SVF + SVS - 1) begin
         errors++;
         $display("FAIL vsync_lines: got %0d ticks rows %0d..%0d, want %0d rows %0d..%0d",
                  vs_ticks, vs_lo, vs_hi, SVS * SHT, SVA + SVF, SVA + SVF + SVS - 1);
      end
      checks++;
      if (vo_ticks != SHA * SVA || !seen_640 || !seen_480) begin
         errors++;
         $display("FAIL video_on_area: got %0d ticks edges=%b%b, want %0d edges=11",
                  vo_ticks, seen_640, seen_480, SHA * SVA);
      end
      checks++;
      if (ft_at.size() != 2 || ft_at[0] != 2 * SHT * SVA || ft_at[1] - ft_at[0] != frame) begin
         errors++;
         $display("FAIL frame_tick_spacing: got %0d pulses first=%0d gap=%0d, want 2 first=%0d gap=%0d",
                  ft_at.size(), (ft_at.size() > 0) ? ft_at[0] : -1,
                  (ft_at.size() > 1) ? ft_at[1] - ft_at[0] : -1, 2 * SHT * SVA, frame);
      end
   endtask

   task automatic test_mid_reset();
      for (int it = 0; it < 3; it++) begin
         int m;
         logic [24:0] e;
         m = (it == 2) ? 2 * SHT * SVA - 1 : int'($urandom_range(100, 1400));
         pulse_reset(1, 2);
         repeat (m) @(negedge clk);
         e = model(m, 2);
         checks++;
         if ({s_col, s_row, s_pt} !== {e[24:5], e[1]}) begin
            errors++;
            $display("FAIL mid_reset_pre[%0d]: got col=%0d row=%0d pt=%b, want col=%0d row=%0d pt=%b",
                     it, s_col, s_row, s_pt, e[24:15], e[14:5], e[1]);
         end
         rst_sm = 1'b1;
         repeat (3) begin
            @(negedge clk);
            checks++;
            if (s_ft !== 1'b0 || s_col !== 10'd0 || s_row !== 10'd0 || s_pt !== 1'b0) begin
               errors++;
               $display("FAIL mid_reset_hold[%0d]: got col=%0d row=%0d pt=%b ft=%b, want 0 0 0 0",
                        it, s_col, s_row, s_pt, s_ft);
            end
         end
         rst_sm = 1'b0;
         for (int n = 0; n < 40; n++) begin
            if (n > 0) @(negedge clk);
            e = model(n, 2);
            checks++;
            if ({s_col, s_row, s_hs, s_vs, s_vo, s_pt, s_ft} !== e) begin
               errors++;
               $display("FAIL mid_reset_after[%0d][%0d]: got col=%0d row=%0d flags=%b%b%b%b%b, want %b",
                        it, n, s_col, s_row, s_hs, s_vs, s_vo, s_pt, s_ft, e[4:0]);
            end
         end
      end
   endtask

   task automatic test_div1();
      int ft_at [$];
      int pt_low = 0;
      int frame = SHT * SVT;
      pulse_reset(2, 2);
      for (int n = 0; n <= 2 * frame + 4; n++) begin
         logic [24:0] e;
         if (n > 0) @(negedge clk);
         e = model(n, 1);
         checks++;
         if ({o_col, o_row, o_hs, o_vs, o_vo, o_pt, o_ft} !== e) begin
            errors++;
            $display("FAIL div1_cycle[%0d]: got col=%0d row=%0d flags=%b%b%b%b%b, want col=%0d row=%0d flags=%b",
                     n, o_col, o_row, o_hs, o_vs, o_vo, o_pt, o_ft, e[24:15], e[14:5], e[4:0]);
         end
         if (n >= 1 && !o_pt) pt_low++;
         if (o_ft) ft_at.push_back(n);
      end
      checks++;
      if (pt_low != 0) begin
         errors++;
         $display("FAIL div1_tick_const: got %0d low clks after reset, want 0", pt_low);
      end
      checks++;
      if (ft_at.size() != 2 || ft_at[0] != SHT * SVA + 1 || ft_at[1] - ft_at[0] != frame) begin
         errors++;
         $display("FAIL div1_frame_spacing: got %0d pulses first=%0d gap=%0d, want 2 first=%0d gap=%0d",
                  ft_at.size(), (ft_at.size() > 0) ? ft_at[0] : -1,
                  (ft_at.size() > 1) ? ft_at[1] - ft_at[0] : -1, SHT * SVA + 1, frame);
      end
   endtask

   initial begin
      test_reset();
      test_pixel_tick();
      test_line();
      test_frames();
      test_mid_reset();
      test_div1();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
